// File: rtl/draw_pkg.sv
// Shared types and board constants for the board redraw controller and RAM port mux.
// No logic; latency and backpressure are defined by the modules that import it.
package draw_pkg;

    localparam int BOARD_W     = 10;
    localparam int BOARD_H     = 24;
    localparam int HIDDEN_ROWS = 4;
    localparam int ADDR_W      = 8;
    localparam int COLOR_W     = 6;

    localparam int LOGIC_BURST_MAX_DEF = 64;
    localparam int DRAW_TIMEOUT_DEF    = 4095;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOGIC = 2'd1,
        ST_START = 2'd2,
        ST_DRAW  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_LOGIC = 2'd1,
        OWN_DRAW  = 2'd2
    } owner_e;

endpackage

// File: rtl/board_draw_ctrl_if.sv
// Signal bundle between game logic / drawer / board RAM and the redraw controller.
// master = surrounding system, slave = board_draw_ctrl.
interface board_draw_ctrl_if;
    import draw_pkg::*;

    logic               redraw_req;
    logic               logic_req;
    logic [ADDR_W-1:0]  logic_addr;
    logic [COLOR_W-1:0] logic_data;
    logic               logic_wren;
    logic               logic_grant;
    logic [ADDR_W-1:0]  draw_addr;
    logic               draw_finished;
    logic               draw_enable;
    logic [ADDR_W-1:0]  ram_addr;
    logic [COLOR_W-1:0] ram_data;
    logic               ram_wren;
    logic               plot;
    logic               busy;
    logic               draw_error;

    modport master (
        output redraw_req, logic_req, logic_addr, logic_data, logic_wren,
        output draw_addr, draw_finished,
        input  logic_grant, draw_enable, ram_addr, ram_data, ram_wren,
        input  plot, busy, draw_error
    );

    modport slave (
        input  redraw_req, logic_req, logic_addr, logic_data, logic_wren,
        input  draw_addr, draw_finished,
        output logic_grant, draw_enable, ram_addr, ram_data, ram_wren,
        output plot, busy, draw_error
    );

endinterface

// File: rtl/ram_port_mux.sv
// Combinational selection of board RAM address/data/write-enable by current owner.
// Zero latency; no backpressure, the owner is decided upstream.
module ram_port_mux
    import draw_pkg::*;
(
    input  owner_e             owner_i,
    input  logic [ADDR_W-1:0]  logic_addr_i,
    input  logic [COLOR_W-1:0] logic_data_i,
    input  logic               logic_wren_i,
    input  logic [ADDR_W-1:0]  draw_addr_i,
    output logic [ADDR_W-1:0]  ram_addr_o,
    output logic [COLOR_W-1:0] ram_data_o,
    output logic               ram_wren_o
);

    always_comb begin
        ram_addr_o = '0;
        ram_data_o = '0;
        ram_wren_o = 1'b0;
        case (owner_i)
            OWN_LOGIC: begin
                ram_addr_o = logic_addr_i;
                ram_data_o = logic_data_i;
                ram_wren_o = logic_wren_i;
            end
            // The drawer only reads the board.
            OWN_DRAW: ram_addr_o = draw_addr_i;
            default: ;
        endcase
    end

endmodule

// File: rtl/board_draw_ctrl.sv
// Redraw sequencer and single-port board RAM arbiter between game logic and drawer.
// Request-to-START is 2 cycles; logic bursts are preempted after LOGIC_BURST_MAX cycles when a redraw waits.
module board_draw_ctrl
    import draw_pkg::*;
#(
    parameter int LOGIC_BURST_MAX = LOGIC_BURST_MAX_DEF,
    parameter int DRAW_TIMEOUT    = DRAW_TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    board_draw_ctrl_if.slave  bus
);

    localparam int BW = $clog2(LOGIC_BURST_MAX + 1);
    localparam int TW = $clog2(DRAW_TIMEOUT + 1);

    state_e          state_q, state_d;
    logic            pending_q, pending_d;
    logic [BW-1:0]   burst_q, burst_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [TW-1:0]   tmo_inc;
    logic            draw_error_q, draw_error_d;
    logic            enter_start;
    owner_e          owner;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            burst_q      <= '0;
            tmo_q        <= '0;
            draw_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            burst_q      <= burst_d;
            tmo_q        <= tmo_d;
            draw_error_q <= draw_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        burst_d      = '0;
        tmo_d        = '0;
        draw_error_d = draw_error_q;
        tmo_inc      = tmo_q + TW'(1);
        case (state_q)
            ST_IDLE: begin
                if (bus.logic_req) begin
                    state_d = ST_LOGIC;
                end else if (pending_q) begin
                    state_d = ST_START;
                end
            end
            ST_LOGIC: begin
                burst_d = (burst_q == BW'(LOGIC_BURST_MAX)) ? burst_q : burst_q + BW'(1);
                if (!bus.logic_req) begin
                    state_d = ST_IDLE;
                end else if (pending_q && (burst_q >= BW'(LOGIC_BURST_MAX - 1))) begin
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_DRAW;
            ST_DRAW: begin
                tmo_d = tmo_inc;
                // The first two cycles may still see finished from the previous run.
                if ((tmo_q >= TW'(2)) && bus.draw_finished) begin
                    state_d = ST_IDLE;
                end else if (tmo_inc == TW'(DRAW_TIMEOUT)) begin
                    draw_error_d = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != ST_LOGIC) burst_d = '0;
        if (state_d != ST_DRAW)  tmo_d   = '0;
    end

    assign enter_start = (state_d == ST_START) && (state_q != ST_START);
    assign pending_d   = bus.redraw_req | (pending_q & ~enter_start);

    always_comb begin
        owner = OWN_NONE;
        if (state_q == ST_LOGIC)     owner = OWN_LOGIC;
        else if (state_q == ST_DRAW) owner = OWN_DRAW;
    end

    ram_port_mux u_mux (
        .owner_i      (owner),
        .logic_addr_i (bus.logic_addr),
        .logic_data_i (bus.logic_data),
        .logic_wren_i (bus.logic_wren),
        .draw_addr_i  (bus.draw_addr),
        .ram_addr_o   (bus.ram_addr),
        .ram_data_o   (bus.ram_data),
        .ram_wren_o   (bus.ram_wren)
    );

    assign bus.logic_grant = (state_q == ST_LOGIC);
    assign bus.draw_enable = (state_q == ST_START);
    assign bus.plot        = (state_q == ST_DRAW) && !bus.draw_finished;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.draw_error  = draw_error_q;

endmodule

// File: tb/tb_board_draw_ctrl.sv
// Directed bench for board_draw_ctrl: redraw sequencing, logic bursts, preemption, stale finished, timeout, reset.
module tb_board_draw_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    board_draw_ctrl_if bus();

    board_draw_ctrl #(.LOGIC_BURST_MAX(64), .DRAW_TIMEOUT(4095)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int good;
        int en_seen;
        int g;

        bus.redraw_req    = 1'b0;
        bus.logic_req     = 1'b0;
        bus.logic_addr    = 8'h00;
        bus.logic_data    = 6'h00;
        bus.logic_wren    = 1'b0;
        bus.draw_addr     = 8'h7C;
        bus.draw_finished = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_enable", bus.draw_enable, 0);
        chk("rst_grant", bus.logic_grant, 0);
        chk("rst_plot", bus.plot, 0);
        chk("rst_err", bus.draw_error, 0);
        chk("rst_ram_addr", bus.ram_addr, 0);
        reset = 1'b0;
        tick();

        // Single redraw pulse, finished after 3200 DRAW cycles
        bus.redraw_req = 1'b1;
        tick();
        bus.redraw_req = 1'b0;
        chk("rd_n1_enable", bus.draw_enable, 0);
        tick();
        chk("rd_start_enable", bus.draw_enable, 1);
        chk("rd_start_busy", bus.busy, 1);
        tick();
        chk("rd_draw_enable_off", bus.draw_enable, 0);
        chk("rd_draw_ram_addr", bus.ram_addr, 8'h7C);
        chk("rd_draw_ram_wren", bus.ram_wren, 0);
        bad = 0;
        for (int i = 0; i < 3200; i++) begin
            if (bus.plot !== 1'b1 || bus.draw_enable !== 1'b0) bad++;
            tick();
        end
        chk("rd_plot_window", bad, 0);
        chk("rd_still_busy", bus.busy, 1);
        bus.draw_finished = 1'b1;
        #1;
        chk("rd_plot_off", bus.plot, 0);
        tick();
        bus.draw_finished = 1'b0;
        chk("rd_busy_fall", bus.busy, 0);
        chk("rd_err", bus.draw_error, 0);
        tick();

        // 10-cycle logic write burst
        bus.logic_req  = 1'b1;
        bus.logic_wren = 1'b1;
        bus.logic_addr = 8'h2A;
        bus.logic_data = 6'h15;
        #1;
        chk("lg_idle_grant", bus.logic_grant, 0);
        chk("lg_idle_ram_addr", bus.ram_addr, 0);
        chk("lg_idle_ram_wren", bus.ram_wren, 0);
        tick();
        good = 0;
        en_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.logic_grant === 1'b1 && bus.ram_wren === 1'b1 &&
                bus.ram_addr === 8'h2A && bus.ram_data === 6'h15) good++;
            if (bus.draw_enable) en_seen++;
            if (i == 9) bus.logic_req = 1'b0;
            tick();
        end
        chk("lg_granted_cycles", good, 10);
        chk("lg_grant_drop", bus.logic_grant, 0);
        chk("lg_ram_wren_off", bus.ram_wren, 0);
        for (int i = 0; i < 4; i++) begin
            if (bus.draw_enable) en_seen++;
            tick();
        end
        chk("lg_no_enable", en_seen, 0);
        bus.logic_wren = 1'b0;

        // Preemption: long burst, redraw on its fifth granted cycle
        bus.logic_req = 1'b1;
        tick();
        g = 0;
        for (int i = 0; i < 200; i++) begin
            bus.redraw_req = (i == 5);
            if (!bus.logic_grant) break;
            g++;
            tick();
        end
        bus.redraw_req = 1'b0;
        chk("pre_granted", g, 64);
        chk("pre_start", bus.draw_enable, 1);
        tick();
        chk("pre_draw_plot", bus.plot, 1);
        tick(); tick(); tick();
        bus.draw_finished = 1'b1;
        tick();
        bus.draw_finished = 1'b0;
        chk("pre_idle_busy", bus.busy, 0);
        tick();
        chk("pre_regrant", bus.logic_grant, 1);
        bus.logic_req = 1'b0;
        tick();
        chk("pre_release", bus.logic_grant, 0);
        tick();

        // Stale finished at START, redraw pulse during DRAW
        bus.draw_finished = 1'b1;
        bus.redraw_req = 1'b1;
        tick();
        bus.redraw_req = 1'b0;
        tick();
        chk("st_start1", bus.draw_enable, 1);
        tick();
        bus.redraw_req = 1'b1;
        chk("st_draw0_busy", bus.busy, 1);
        tick();
        bus.redraw_req = 1'b0;
        chk("st_stale_ignored", bus.busy, 1);
        tick();
        chk("st_draw2_busy", bus.busy, 1);
        tick();
        chk("st_done_idle", bus.busy, 0);
        chk("st_done_enable", bus.draw_enable, 0);
        tick();
        chk("st_start2", bus.draw_enable, 1);
        tick(); tick(); tick();
        chk("st_draw2_running", bus.busy, 1);
        tick();
        chk("st_draw2_done", bus.busy, 0);
        bus.draw_finished = 1'b0;
        tick();

        // Timeout with finished held low
        bus.redraw_req = 1'b1;
        tick();
        bus.redraw_req = 1'b0;
        tick();
        chk("to_start", bus.draw_enable, 1);
        tick();
        for (int i = 0; i < 4094; i++) tick();
        chk("to_last_busy", bus.busy, 1);
        chk("to_last_err", bus.draw_error, 0);
        tick();
        chk("to_idle", bus.busy, 0);
        chk("to_err_set", bus.draw_error, 1);
        tick();
        bus.redraw_req = 1'b1;
        tick();
        bus.redraw_req = 1'b0;
        tick();
        chk("to_redraw_start", bus.draw_enable, 1);
        tick(); tick(); tick();
        bus.draw_finished = 1'b1;
        tick();
        bus.draw_finished = 1'b0;
        chk("to_redraw_done", bus.busy, 0);
        chk("to_err_sticky", bus.draw_error, 1);
        tick();

        // Reset mid-DRAW with a pending request latched
        bus.redraw_req = 1'b1;
        tick();
        bus.redraw_req = 1'b0;
        tick(); tick(); tick();
        bus.redraw_req = 1'b1;
        tick();
        bus.redraw_req = 1'b0;
        chk("rs_draw_plot", bus.plot, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rs_async_busy", bus.busy, 0);
        chk("rs_async_plot", bus.plot, 0);
        chk("rs_async_err", bus.draw_error, 0);
        chk("rs_async_ram_addr", bus.ram_addr, 0);
        tick(); tick();
        reset = 1'b0;
        en_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.draw_enable || bus.busy) en_seen++;
            tick();
        end
        chk("rs_no_spurious", en_seen, 0);

        // Reset mid-LOGIC
        bus.logic_req  = 1'b1;
        bus.logic_wren = 1'b1;
        bus.logic_addr = 8'h33;
        tick();
        chk("rl_grant", bus.logic_grant, 1);
        #2;
        reset = 1'b1;
        bus.logic_req = 1'b0;
        #1;
        chk("rl_async_grant", bus.logic_grant, 0);
        chk("rl_async_wren", bus.ram_wren, 0);
        chk("rl_async_addr", bus.ram_addr, 0);
        tick();
        reset = 1'b0;
        tick(); tick();
        chk("rl_after_busy", bus.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_draw_ctrl.md
# board_draw_ctrl

Sequences full-board redraws and shares the single-port board RAM between the board drawer and game logic. Latches redraw requests, pulses the drawer's `enable`, and waits for its `finished`. Grants the RAM port to game-logic read/write bursts between redraws, and muxes address, data and write-enable onto the RAM. Sits between the game FSM, the drawer and the board RAM; its `plot` output gates the VGA adapter.

## Interface
Parameters:
- `LOGIC_BURST_MAX`, default 64: maximum consecutive granted logic cycles while a redraw is pending.
- `DRAW_TIMEOUT`, default 4095: maximum number of DRAW cycles before the draw is aborted.

Ports:
- `clk`  in  1: system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `redraw_req`  in  1: one-cycle pulse or level. Sets the pending-redraw latch.
- `logic_req`  in  1: game logic requests the RAM port. Held for the whole burst.
- `logic_addr`  in  8: game-logic RAM address.
- `logic_data`  in  6: game-logic write colour.
- `logic_wren`  in  1: game-logic write strobe. Qualified by `logic_grant`.
- `logic_grant`  out  1: RAM port owned by game logic this cycle.
- `draw_addr`  in  8: drawer RAM address.
- `draw_finished`  in  1: drawer completion flag.
- `draw_enable`  out  1: drawer start pulse. The drawer resets on its rising edge.
- `ram_addr`  out  8: muxed RAM address.
- `ram_data`  out  6: RAM write data.
- `ram_wren`  out  1: RAM write enable.
- `plot`  out  1: VGA plot enable.
- `busy`  out  1: state is not IDLE.
- `draw_error`  out  1: sticky flag; a draw timed out.

## Operation
- States: IDLE, LOGIC, START, DRAW.
- Pending latch:
  - Set on any cycle with `redraw_req`=1, including during DRAW.
  - Cleared on entry to START. Set wins over clear in the same cycle.
- IDLE:
  - `logic_req` → LOGIC.
  - Otherwise, pending → START.
  - Otherwise stay in IDLE.
- LOGIC:
  - `logic_grant`=1.
  - Burst counter increments each cycle.
  - `logic_req`=0 → IDLE.
  - Counter reaching `LOGIC_BURST_MAX` with pending=1 → START (preemption). Logic sees `logic_grant` drop and must hold its request.
  - Counter saturates when no redraw is pending.
  - Counter clears on leaving LOGIC.
- START: lasts exactly one cycle. `draw_enable`=1. Next state DRAW.
- DRAW:
  - Timeout counter runs from 0.
  - `draw_finished` is ignored while the counter is below 2 (stale flag from the previous run).
  - `draw_finished` sampled at 1 → IDLE.
  - Counter reaching `DRAW_TIMEOUT` → set `draw_error`, go to IDLE.
- Port mux:
  - DRAW: `ram_addr`=`draw_addr`, `ram_wren`=0.
  - LOGIC: `ram_addr`=`logic_addr`, `ram_data`=`logic_data`, `ram_wren`=`logic_wren`.
  - Otherwise: `ram_addr`=0, `ram_data`=0, `ram_wren`=0.
- `plot` = DRAW and not `draw_finished`.
- `draw_error` clears only on `reset`.

## Timing
- Reset state: IDLE. All outputs 0, pending 0, both counters 0.
- State, pending latch and counters are registered. Outputs are decoded combinationally from the registered state. `ram_addr`/`ram_wren` are combinational passthroughs of the inputs.
- `redraw_req` in cycle n with no logic request:
  - START in n+2 (latch in n+1, transition in n+2).
  - DRAW from n+3.
- `logic_req` rising in IDLE at cycle n → `logic_grant` in n+1.
- Simultaneous `logic_req` and pending in IDLE: logic is granted first and can be preempted after `LOGIC_BURST_MAX` cycles.
- `reset` mid-DRAW: the drawer is abandoned. `draw_enable` stays 0 until a new request.
- RAM read latency (1 cycle) belongs to the consumers. This block adds no pipeline delay on the address path.

## Structure
- Shared package `draw_pkg`:
  - State enum.
  - Board constants: width 10, height 24, hidden rows 4, address width 8, colour width 6.
  - Defaults for `LOGIC_BURST_MAX` and `DRAW_TIMEOUT`.
- Sub-module `ram_port_mux`: combinational select of address/data/wren by owner. Reused by any future third requester.
- FSM, latch and counters live in `board_draw_ctrl`.

## Test plan
- Reset, then one `redraw_req` pulse:
  - `draw_enable` high for exactly 1 cycle, 2 cycles after the pulse.
  - `plot`=1 until `draw_finished` is driven high 3200 cycles later.
  - `busy` falls the following cycle.
- `logic_req` held 10 cycles with `logic_wren`=1, `logic_addr`=0x2A, `logic_data`=0x15:
  - `ram_wren`=1, `ram_addr`=0x2A, `ram_data`=0x15 for 10 granted cycles.
  - No `draw_enable`.
- `logic_req` held 200 cycles, `redraw_req` at cycle 5: grant drops after 64 granted cycles, START follows, and logic is re-granted after the draw completes.
- `redraw_req` pulses during DRAW, with `draw_finished` already high at START: the stale `finished` is ignored, and a second START occurs immediately after the first draw completes.
- `draw_finished` tied low: after 4095 DRAW cycles, `draw_error`=1 and state returns to IDLE. A later redraw still runs, and `draw_error` stays 1.
- `reset` asserted mid-DRAW and mid-LOGIC: all outputs 0 asynchronously, pending cleared, no spurious `draw_enable` after release.
